param_register_file: RTL
========================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits (1..64).
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG0, default 0, when 1 entry 0 reads zero and ignores writes.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 we  input  1  write enable.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  write data.
REQ-009 rd_en1, rd_en2  input  1 each  read request, ports 1/2.
REQ-010 rd_addr1, rd_addr2  input  ADDR_W each  read address, ports 1/2.
REQ-011 rd_data1, rd_data2  output  DATA_W each  registered read data.
REQ-012 rd_valid1, rd_valid2  output  1 each  read data valid strobe.
REQ-013 rsv  input  1  reserve entry rsv_addr (mark pending).
REQ-014 rsv_addr  input  ADDR_W  entry to reserve.
REQ-015 rd_pend1, rd_pend2  output  1 each  registered pending flag of the entry read.

Function
REQ-016 Write: on rising edge with we=1, entry wr_addr SHALL take wr_data; we=0 leaves storage unchanged.
REQ-017 Read latency SHALL be exactly 1 cycle: rd_en sampled at edge N yields rd_data, rd_pend and rd_valid=1 after edge N.
REQ-018 rd_valid SHALL be 1 only in the cycle after rd_en=1, else 0; rd_data SHALL hold its last value while rd_en=0.
REQ-019 Both read ports SHALL operate independently and concurrently, including same address on both.
REQ-020 Pending scoreboard: one bit per entry; rsv=1 SHALL set bit rsv_addr; we=1 SHALL clear bit wr_addr.
REQ-021 rsv and we to the same address in one cycle: data written, pending bit SHALL end set (reservation wins).
REQ-022 rsv and we to different addresses in one cycle: both updates SHALL take effect.
REQ-023 rd_pend SHALL reflect the pending bit state before the edge the read is sampled on (no scoreboard bypass).
REQ-024 ZERO_REG0=1: reads of entry 0 SHALL return 0 and rd_pend=0; writes and reservations to entry 0 SHALL be ignored.
REQ-025 Addresses SHALL cover all DEPTH entries with no out-of-range case; no address wrap logic needed.

Reset
REQ-026 While rst_n=0 at a rising edge, all entries SHALL clear to 0 and all pending bits to 0.
REQ-027 During reset rd_data1/2 SHALL be 0, rd_valid1/2 SHALL be 0, rd_pend1/2 SHALL be 0; writes, reads, reservations ignored.
REQ-028 Reset asserted mid-operation SHALL drop any in-flight read (no rd_valid in cycle after reset edge).
REQ-029 First read request accepted at first edge with rst_n=1.

Configuration
REQ-030 Macro REGFILE_WR_BYPASS_EN defined: read of the address being written in the same cycle SHALL return wr_data (write-first).
REQ-031 Macro REGFILE_WR_BYPASS_EN undefined: same-cycle read of written address SHALL return old stored value (read-first).
REQ-032 Bypass SHALL never apply to entry 0 when ZERO_REG0=1, nor affect rd_pend.

Verification (defaults DATA_W=8, ADDR_W=3)
REQ-033 Reset, then read all 8 entries on both ports -> rd_data=00, rd_pend=0, rd_valid=1 one cycle after each rd_en.
REQ-034 Write 0xAA@0, 0x55@1, 0xCC@7, then rd_addr1=7, rd_addr2=1 -> next cycle rd_data1=CC, rd_data2=55.
REQ-035 Same-cycle we=1 wr_addr=3 wr_data=0x3C and rd_en1 rd_addr1=3 (old 0x11) -> rd_data1=3C with macro, 11 without.
REQ-036 rsv@5, read 5 -> rd_pend1=1; write 0x77@5, read 5 -> rd_pend1=0, data 77; rsv+we@5 same cycle -> pend=1, data new.
REQ-037 ZERO_REG0=1: write 0xFF@0, rsv@0, read 0 -> rd_data=00, rd_pend=0.
REQ-038 Write 0x99@2, assert rst_n=0 one cycle with rd_en1 high -> no rd_valid after reset edge; read 2 -> 00.

Source files
------------

// File: rtl/param_register_file.sv
// Multi-port register file: one write port, two registered read ports, and a pending bit per entry.
// Define REGFILE_WR_BYPASS_EN for write-first reads; leave it undefined for read-first reads.
module param_register_file #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid1,
  output logic              rd_valid2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rd_pend1,
  output logic              rd_pend2
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG0 != 0);

  // Storage is cleared on reset, so it is kept in flops rather than block RAM.
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  wr_hit_vec;
  logic [DEPTH-1:0]  rsv_hit_vec;

  genvar gi;

  // Per-entry decode. A hard-wired zero entry never sees a hit.
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [ADDR_W-1:0] ENTRY  = ADDR_W'(gi);
    localparam bit                LOCKED = HAS_ZERO && (gi == 0);
    assign wr_hit_vec[gi]  = we  && (wr_addr  == ENTRY) && !LOCKED;
    assign rsv_hit_vec[gi] = rsv && (rsv_addr == ENTRY) && !LOCKED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i]  <= '0;
        pend_reg[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit_vec[i]) begin
          mem_reg[i] <= wr_data;
        end
        // A reservation landing with a write to the same entry leaves it pending.
        if (rsv_hit_vec[i]) begin
          pend_reg[i] <= 1'b1;
        end else if (wr_hit_vec[i]) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  logic [1:0]        rd_en_vec;
  logic [ADDR_W-1:0] rd_addr_vec [2];

  assign rd_en_vec      = {rd_en2, rd_en1};
  assign rd_addr_vec[0] = rd_addr1;
  assign rd_addr_vec[1] = rd_addr2;

  // Two identical, independent read ports.
  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_next;
    logic              valid_reg;
    logic              pend_reg_q;
    logic              pend_next;
    logic              zero_hit;

    assign zero_hit = HAS_ZERO && (rd_addr_vec[gi] == '0);

    always_comb begin
      data_next = mem_reg[rd_addr_vec[gi]];
`ifdef REGFILE_WR_BYPASS_EN
      if (we && (wr_addr == rd_addr_vec[gi])) begin
        data_next = wr_data;
      end
`endif
      if (zero_hit) begin
        data_next = '0;
      end
      // The pending flag is never bypassed: it shows the state before this edge.
      pend_next = pend_reg[rd_addr_vec[gi]] && !zero_hit;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_reg   <= '0;
        valid_reg  <= 1'b0;
        pend_reg_q <= 1'b0;
      end else begin
        valid_reg <= rd_en_vec[gi];
        if (rd_en_vec[gi]) begin
          data_reg   <= data_next;
          pend_reg_q <= pend_next;
        end
      end
    end
  end

  assign rd_data1  = g_rd[0].data_reg;
  assign rd_valid1 = g_rd[0].valid_reg;
  assign rd_pend1  = g_rd[0].pend_reg_q;
  assign rd_data2  = g_rd[1].data_reg;
  assign rd_valid2 = g_rd[1].valid_reg;
  assign rd_pend2  = g_rd[1].pend_reg_q;

endmodule
